// File: rtl/issue_slot_scheduler.sv
// Issue-slot scheduler: round-robin pick among warp slots whose head instruction
// has no register hazard, feeding a one-entry registered output stage.
module issue_slot_scheduler #(
    parameter int unsigned NUM_SLOTS = 4,
    parameter int unsigned NUM_REGS  = 64,
    parameter int unsigned NR_BITS   = 6,
    parameter int unsigned DATAW     = 64,
    parameter int unsigned SLOT_BITS = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_SLOTS-1:0]         in_valid,
    input  logic [NUM_SLOTS*DATAW-1:0]   in_data,
    input  logic [NUM_SLOTS*NR_BITS-1:0] in_rd,
    input  logic [NUM_SLOTS*NR_BITS-1:0] in_rs1,
    input  logic [NUM_SLOTS*NR_BITS-1:0] in_rs2,
    input  logic [NUM_SLOTS*NR_BITS-1:0] in_rs3,
    input  logic [NUM_SLOTS-1:0]         in_wb,
    output logic [NUM_SLOTS-1:0]         in_ready,
    input  logic                         wb_valid,
    input  logic                         wb_eop,
    input  logic [SLOT_BITS-1:0]         wb_slot,
    input  logic [NR_BITS-1:0]           wb_rd,
    output logic                         out_valid,
    output logic [DATAW-1:0]             out_data,
    output logic [SLOT_BITS-1:0]         out_slot,
    input  logic                         out_ready,
    output logic [31:0]                  perf_hazard_cycles
);

    localparam int unsigned STARVE_LIMIT = 100000;

    logic [NUM_SLOTS-1:0][NUM_REGS-1:0] r_inuse;
    logic [SLOT_BITS-1:0]               r_rr_ptr;
    logic                               r_out_valid;
    logic [DATAW-1:0]                   r_out_data;
    logic [SLOT_BITS-1:0]               r_out_slot;
    logic [31:0]                        r_perf;
    logic [NUM_SLOTS-1:0][16:0]         r_starve;

    logic [NUM_SLOTS-1:0] w_busy;
    logic [NUM_SLOTS-1:0] w_elig;
    logic [NUM_SLOTS-1:0] w_grant;
    logic [SLOT_BITS-1:0] w_grant_idx;
    logic                 w_found;
    logic                 w_can_accept;
    logic                 w_fire;
    logic                 w_hazard;
    logic [NR_BITS-1:0]   w_g_rd;
    logic [DATAW-1:0]     w_g_data;
    logic                 w_set;
    logic                 w_clr;

    // Per-slot hazard: any source or destination register still in flight.
    always_comb begin
        w_busy = '0;
        for (int s = 0; s < NUM_SLOTS; s++) begin
            w_busy[s] = r_inuse[s][in_rd[s*NR_BITS +: NR_BITS]]
                      | r_inuse[s][in_rs1[s*NR_BITS +: NR_BITS]]
                      | r_inuse[s][in_rs2[s*NR_BITS +: NR_BITS]]
                      | r_inuse[s][in_rs3[s*NR_BITS +: NR_BITS]];
        end
        w_elig   = in_valid & ~w_busy;
        w_hazard = |(in_valid & w_busy);
    end

    // Round-robin pick: first eligible slot at or above the pointer, wrapping.
    always_comb begin
        logic [SLOT_BITS-1:0] idx;
        w_found     = 1'b0;
        w_grant_idx = '0;
        idx         = '0;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            idx = r_rr_ptr + SLOT_BITS'(i);
            if (!w_found && w_elig[idx]) begin
                w_found     = 1'b1;
                w_grant_idx = idx;
            end
        end
        w_grant      = w_found ? (NUM_SLOTS'(1) << w_grant_idx) : '0;
        w_can_accept = ~r_out_valid | out_ready;
        in_ready     = w_grant & {NUM_SLOTS{w_can_accept & ~reset}};
        w_fire       = |in_ready;
        w_g_rd       = in_rd[int'(w_grant_idx)*NR_BITS +: NR_BITS];
        w_g_data     = in_data[int'(w_grant_idx)*DATAW +: DATAW];
        w_set        = w_fire & in_wb[w_grant_idx];
        w_clr        = wb_valid & wb_eop;
    end

    // In-use bitmap; the set is written last so it wins over a same-bit clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_inuse <= '0;
        end else begin
            if (w_clr) r_inuse[wb_slot][wb_rd] <= 1'b0;
            if (w_set) r_inuse[w_grant_idx][w_g_rd] <= 1'b1;
        end
    end

    // Output pipe register, round-robin pointer and hazard-stall counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_slot  <= '0;
            r_rr_ptr    <= '0;
            r_perf      <= '0;
        end else begin
            if (w_fire) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_g_data;
                r_out_slot  <= w_grant_idx;
                r_rr_ptr    <= w_grant_idx + 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_hazard && !w_fire) r_perf <= r_perf + 32'd1;
        end
    end

    // Starvation watchdog: cycles each slot has waited with a valid head.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_starve <= '0;
        end else begin
            for (int s = 0; s < NUM_SLOTS; s++) begin
                if (in_valid[s] && !in_ready[s]) begin
                    if (r_starve[s] != 17'(STARVE_LIMIT)) r_starve[s] <= r_starve[s] + 17'd1;
                end else begin
                    r_starve[s] <= '0;
                end
            end
        end
    end

    // Simulation checks: clearing an idle register, and a slot starved too long.
    always_ff @(posedge clk) begin
        if (!reset && w_clr) begin
            assert (r_inuse[wb_slot][wb_rd] ||
                    (w_set && w_grant_idx == wb_slot && w_g_rd == wb_rd))
            else $error("writeback to idle register slot=%0d rd=%0d", wb_slot, wb_rd);
        end
        for (int s = 0; s < NUM_SLOTS; s++) begin
            assert (reset || r_starve[s] < 17'(STARVE_LIMIT))
            else $error("slot %0d starved", s);
        end
    end

    assign out_valid          = r_out_valid;
    assign out_data           = r_out_data;
    assign out_slot           = r_out_slot;
    assign perf_hazard_cycles = r_perf;

endmodule

// File: doc/issue_slot_scheduler.md
Name: issue_slot_scheduler

Overview:
- Per-issue-lane scheduler that arbitrates among NUM_SLOTS warp slots, each presenting its head instruction from the ibuffer.
- Keeps a per-slot register in-use bitmap, so only hazard-free instructions are eligible.
- Grants one eligible slot per cycle, round-robin, into a one-entry registered output stage that feeds operand fetch.
- Writebacks clear in-use bits.

Parameters:
- NUM_SLOTS, 4, number of warp slots arbitrated (power of two, ≥2)
- NUM_REGS, 64, registers tracked per slot
- NR_BITS, 6, register index width, clog2(NUM_REGS)
- DATAW, 64, opaque instruction payload width
- SLOT_BITS, 2, clog2(NUM_SLOTS)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- in_valid  in  NUM_SLOTS  per-slot head instruction valid
- in_data  in  NUM_SLOTS*DATAW  per-slot payload
- in_rd, in_rs1, in_rs2, in_rs3  in  NUM_SLOTS*NR_BITS each  per-slot register indices
- in_wb  in  NUM_SLOTS  per-slot instruction writes rd
- in_ready  out  NUM_SLOTS  one-hot pop to granted slot
- wb_valid  in  1  writeback beat valid
- wb_eop  in  1  last beat of writeback
- wb_slot  in  SLOT_BITS  writeback slot
- wb_rd  in  NR_BITS  writeback register
- out_valid  out  1  issued instruction valid
- out_data  out  DATAW  issued payload
- out_slot  out  SLOT_BITS  slot of issued instruction
- out_ready  in  1  downstream accept
- perf_hazard_cycles  out  32  count of hazard-stall cycles

Behaviour:
- Reset (synchronous, active-high): clk and reset are the only clock and reset. Reset clears all in-use bits, rr_ptr=0, out_valid=0, out_data=0, out_slot=0, perf_hazard_cycles=0. in_ready is combinational and is 0 while reset is high. Reset mid-transfer drops the held output entry.
- Hazard, per slot s: busy[s] = inuse[s][rd] | inuse[s][rs1] | inuse[s][rs2] | inuse[s][rs3]. rd is checked for WAW. All indices are tracked, including 0. There is no writeback bypass: a bit cleared in cycle t makes its register usable in cycle t+1.
- Eligibility: elig[s] = in_valid[s] & ~busy[s].
- Grant: round-robin, priority starts at rr_ptr and goes upward modulo NUM_SLOTS. grant is one-hot or zero.
- Output stage is a pipe register. can_accept = ~out_valid | out_ready.
- in_ready[s] = grant[s] & can_accept & ~reset.
- fire = |in_ready.
- On fire: the output register loads the granted data and slot, out_valid<=1, and rr_ptr<=grant_idx+1 (wraps).
- Without fire: if out_ready, out_valid<=0, otherwise the entry is held stable. rr_ptr is unchanged.
- Throughput is 1 instruction/cycle under continuous out_ready. Latency from in_ready to out_valid is 1 cycle.
- Stability: out_data and out_slot must not change while out_valid & ~out_ready.
- In-use set: on fire with in_wb[g]=1, inuse[g][rd_g]<=1. With in_wb=0, nothing is set.
- In-use clear: when wb_valid & wb_eop, inuse[wb_slot][wb_rd]<=0. Beats with wb_eop=0 have no effect.
- Simultaneous set and clear of the same slot/register: set wins. Set and clear of different bits both apply.
- Writeback to a register whose bit is clear is illegal. A simulation assertion flags it, and the RTL result is a no-op.
- perf_hazard_cycles: +1 in each cycle where |(in_valid & busy) and no fire occurs. It wraps at 2^32.
- Simulation-only: a per-slot counter asserts if in_valid & ~in_ready persists for 100000 cycles.

Test Plan:
1. Round-robin: all 4 slots valid, no hazards, out_ready=1.
   - Required: grants in order 0,1,2,3,0 on consecutive cycles; out_slot sequence trails by 1 cycle.
2. RAW hazard: slot1 issues rd=5 with wb=1; next, slot1 presents rs1=5.
   - Required: slot1 is never granted while the bit is set, and perf_hazard_cycles increments each such cycle.
   - Then apply wb_valid=1, wb_eop=1, wb_slot=1, wb_rd=5 at cycle t. Required: slot1 is granted at t+1, not at t.
3. Backpressure: out_ready=0 for 3 cycles with slots 0,2 valid.
   - Required: exactly one entry (slot0) is held with data stable, and in_ready=0.
   - On out_ready=1: slot0 is accepted and slot2 is granted the same cycle.
4. Set/clear collision: fire slot3 with rd=7, wb=1 in the same cycle as a writeback of slot3, rd=7, eop=1.
   - Required: inuse[3][7]=1 afterwards; a later rs2=7 from slot3 stalls.
5. Non-eop beat and cross-slot isolation: slot0 has rd=9 busy; apply a writeback with wb_eop=0 for slot0, rd=9.
   - Required: the bit stays set. Slot2, whose rs1=9 is independent of slot0, is granted.
6. Reset mid-operation: out_valid=1 with out_ready=0 and several in-use bits set; assert reset for 1 cycle.
   - Required: out_valid=0, all slots eligible, first grant after reset goes to slot0, counter=0.
